// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit path: the encoding of the TX output
// mux select and the frame controller state encoding.
package uart_tx_pkg;

  // TX output mux select values (mux start/stop inputs are tied 0/1 upstream)
  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  // Frame controller state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Mux select that goes with a given state; IDLE and STOP both hold the line high
  function automatic logic [1:0] muxSelFor(input logic [2:0] state);
    logic [1:0] sel;
    case (state)
      ST_START:  sel = MUX_START;
      ST_DATA:   sel = MUX_DATA;
      ST_PARITY: sel = MUX_PAR;
      default:   sel = MUX_STOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for one UART frame. The LSB of the
// shift register is the serial data bit; done flags the last payload bit.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  shift_en,
  output logic                  done,
  output logic                  ser_data
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_count;
  logic                  w_lastBit;

  assign w_lastBit = (r_count == LAST_BIT);
  assign done      = shift_en && w_lastBit;
  assign ser_data  = r_shift[0];

  // Load a new byte, or shift it out LSB first while the counter tracks position;
  // the counter returns to 0 on the last bit so it never runs past DATA_WIDTH-1
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (load) begin
      r_shift <= data_in;
      r_count <= '0;
    end else if (shift_en) begin
      r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
      r_count <= w_lastBit ? '0 : (r_count + CW'(1));
    end
  end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller. Sequences start, payload (LSB first),
// optional parity and stop bits, driving the select of the downstream 4:1 TX
// mux together with the serial data and parity bits it consumes.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  logic [2:0] r_state;
  logic [2:0] w_nextState;
  logic [1:0] r_muxSel;
  logic       r_busy;
  logic       r_parEn;
  logic       r_parBit;
  logic       w_load;
  logic       w_shiftEn;
  logic       w_lastBit;
  logic       w_serData;

  // A byte is only taken while idle; anything offered mid-frame is dropped
  assign w_load    = (r_state == ST_IDLE) && DATA_VALID;
  assign w_shiftEn = (r_state == ST_DATA);

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk      (CLK),
    .reset    (RST),
    .load     (w_load),
    .data_in  (P_DATA),
    .shift_en (w_shiftEn),
    .done     (w_lastBit),
    .ser_data (w_serData)
  );

  // Frame sequencing: START and PARITY/STOP are single cycles, DATA lasts until the serializer reports its last bit
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (DATA_VALID) w_nextState = ST_START;
      ST_START:  w_nextState = ST_DATA;
      ST_DATA:   if (w_lastBit) w_nextState = r_parEn ? ST_PARITY : ST_STOP;
      ST_PARITY: w_nextState = ST_STOP;
      ST_STOP:   w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // State plus registered mux select and busy, both decoded from the next state so they line up with it
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_muxSel <= MUX_STOP;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_muxSel <= muxSelFor(w_nextState);
      r_busy   <= (w_nextState != ST_IDLE);
    end
  end

  // Frame options are captured with the byte so later input changes cannot disturb the frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_parEn  <= 1'b0;
      r_parBit <= 1'b0;
    end else if (w_load) begin
      r_parEn  <= PAR_EN;
      r_parBit <= (^P_DATA) ^ PAR_TYP;
    end
  end

  assign mux_sel  = r_muxSel;
  assign busy     = r_busy;
  assign par_bit  = r_parBit;
  assign ser_data = w_serData;

endmodule
